// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a direct mode and an auto-scan mode with programmable dwell.
// Define DECODER_BLANK_EN to insert BLANK_CYC all-inactive cycles before each scanned index.
module decoder_scan #(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic               i_opt,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [NUM_OUT-1:0] o_y,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_step
);

`ifdef DECODER_BLANK_EN
  typedef enum logic [1:0] {OFF, DIRECT, DWELL, BLANK} state_t;
  localparam logic [DWELL_W-1:0] BlankLast = DWELL_W'(BLANK_CYC - 1);
`else
  typedef enum logic [1:0] {OFF, DIRECT, DWELL} state_t;
  logic unused_blank;
  assign unused_blank = (BLANK_CYC < 1);
`endif

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_OUT - 1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     idx_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;
  logic                 step_nxt;
  logic                 active;
  logic [NUM_OUT-1:0]   y_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= OFF;
      cnt    <= '0;
      o_idx  <= '0;
      o_step <= 1'b0;
      o_y    <= '1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_idx  <= idx_nxt;
      o_step <= step_nxt;
      o_y    <= y_nxt;
    end
  end

  // Outputs are decoded from the next state so o_y/o_idx appear one edge after sampling.
  always_comb begin
    state_nxt = state;
    idx_nxt   = o_idx;
    cnt_nxt   = cnt;
    step_nxt  = 1'b0;
    active    = 1'b0;

    if (!i_en) begin
      state_nxt = OFF;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else if (!i_mode) begin
      state_nxt = DIRECT;
      idx_nxt   = i_sel;
      cnt_nxt   = '0;
      active    = 1'b1;
    end else begin
      case (state)
        DWELL: begin
          if (cnt >= i_dwell) begin
            idx_nxt  = (o_idx == LastIdx) ? '0 : o_idx + SEL_W'(1);
            cnt_nxt  = '0;
            step_nxt = 1'b1;
`ifdef DECODER_BLANK_EN
            state_nxt = BLANK;
`else
            active    = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
            active  = 1'b1;
          end
        end
`ifdef DECODER_BLANK_EN
        BLANK: begin
          if (cnt >= BlankLast) begin
            state_nxt = DWELL;
            cnt_nxt   = '0;
            active    = 1'b1;
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
          end
        end
`endif
        default: begin
          state_nxt = DWELL;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          active    = 1'b1;
        end
      endcase
    end

    // Out-of-range direct indices match no bit and fall out as all-inactive.
    for (int i = 0; i < NUM_OUT; i++) begin
      y_nxt[i] = (active && (idx_nxt == SEL_W'(i))) ? i_opt : ~i_opt;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: two instances (8 and 6 outputs) share one stimulus stream.
module tb_decoder_scan;

  localparam int BLANK_CYC = 2;
`ifdef DECODER_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam int OFF_S = 0, DIR_S = 1, DWL_S = 2, BLK_S = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, opt;
  logic [2:0]  sel;
  logic [15:0] dwell;
  logic [7:0]  y8;
  logic [5:0]  y6;
  logic [2:0]  idx8, idx6;
  logic        step8, step6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y8;
    logic [2:0] i8;
    logic       s8;
    logic [7:0] y6;
    logic [2:0] i6;
    logic       s6;
  } exp_t;
  exp_t sb[$];

  int m_state[2];
  int m_idx[2];
  int m_cnt[2];
  int nout[2] = '{8, 6};

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(16), .BLANK_CYC(BLANK_CYC)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel),
    .i_opt(opt), .i_dwell(dwell), .o_y(y8), .o_idx(idx8), .o_step(step8)
  );

  decoder_scan #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(16), .BLANK_CYC(BLANK_CYC)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel),
    .i_opt(opt), .i_dwell(dwell), .o_y(y6), .o_idx(idx6), .o_step(step6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] patY(input int n, input bit act, input int idx, input bit pol);
    logic [7:0] v;
    v = 8'h00;
    for (int b = 0; b < n; b++) v[b] = (act && b == idx) ? pol : !pol;
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = OFF_S;
      m_idx[k]   = 0;
      m_cnt[k]   = 0;
    end
  endtask

  // Advance the behavioural model by one edge; returns the values the DUT should then show.
  task automatic modelStep(input int k, output logic [7:0] ey, output logic [2:0] ei, output logic es);
    int ns, ni, nc;
    bit act;
    ns = m_state[k]; ni = m_idx[k]; nc = m_cnt[k];
    act = 1'b0; es = 1'b0;
    if (!en) begin
      ns = OFF_S; ni = 0; nc = 0;
    end else if (!mode) begin
      ns = DIR_S; ni = int'(sel); nc = 0; act = (int'(sel) < nout[k]);
    end else if (m_state[k] == DWL_S) begin
      if (m_cnt[k] >= int'(dwell)) begin
        ni = (m_idx[k] + 1) % nout[k]; nc = 0; es = 1'b1;
        ns = BLANK_ON ? BLK_S : DWL_S;
        act = !BLANK_ON;
      end else begin
        nc = m_cnt[k] + 1; act = 1'b1;
      end
    end else if (m_state[k] == BLK_S) begin
      if (m_cnt[k] + 1 >= BLANK_CYC) begin
        ns = DWL_S; nc = 0; act = 1'b1;
      end else begin
        nc = m_cnt[k] + 1;
      end
    end else begin
      ns = DWL_S; ni = 0; nc = 0; act = 1'b1;
    end
    m_state[k] = ns; m_idx[k] = ni; m_cnt[k] = nc;
    ey = patY(nout[k], act, ni, opt);
    ei = 3'(ni);
  endtask

  // Called at a falling edge (or mid-low phase); returns at the next falling edge.
  task automatic applyStimulus(input logic e, input logic m, input logic [2:0] s,
                               input logic p, input logic [15:0] d);
    exp_t ex, got;
    en = e; mode = m; sel = s; opt = p; dwell = d;
    modelStep(0, ex.y8, ex.i8, ex.s8);
    modelStep(1, ex.y6, ex.i6, ex.s6);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      checkOutput("y8",    32'(y8),    32'(got.y8));
      checkOutput("idx8",  32'(idx8),  32'(got.i8));
      checkOutput("step8", 32'(step8), 32'(got.s8));
      checkOutput("y6",    32'({2'b00, y6}), 32'(got.y6));
      checkOutput("idx6",  32'(idx6),  32'(got.i6));
      checkOutput("step6", 32'(step6), 32'(got.s6));
    end
    @(negedge clk);
  endtask

  initial begin
    int first, per, guard;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; opt = 1'b0; dwell = 16'd0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_y8",   32'(y8),    32'hFF);
    checkOutput("rst_idx8", 32'(idx8),  32'h0);
    checkOutput("rst_step", 32'(step8), 32'h0);
    checkOutput("rst_y6",   32'({2'b00, y6}), 32'h3F);
    rst_n = 1'b1;

    // Direct mode and polarity
    applyStimulus(1, 0, 3'd5, 0, 16'd0);
    checkOutput("dir5_low",  32'(y8), 32'hDF);
    checkOutput("dir5_idx",  32'(idx8), 32'd5);
    applyStimulus(1, 0, 3'd5, 1, 16'd0);
    checkOutput("dir5_high", 32'(y8), 32'h20);
    applyStimulus(1, 0, 3'd7, 1, 16'd0);
    checkOutput("oor_y6",   32'({2'b00, y6}), 32'h00);
    checkOutput("oor_idx6", 32'(idx6), 32'd7);
    applyStimulus(1, 0, 3'd7, 0, 16'd0);
    checkOutput("oor_y6_low", 32'({2'b00, y6}), 32'h3F);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'd0);

    // Scan walk, dwell = 2; index derived from elapsed cycles
    first = 3;
    per   = 3 + (BLANK_ON ? BLANK_CYC : 0);
    for (int t = 0; t < 30; t++) begin
      applyStimulus(1, 1, 3'd0, 1, 16'd2);
      checkOutput("walk_idx", 32'(idx8), (t < first) ? 32'd0 : 32'((1 + (t - first) / per) % 8));
    end

    // Dwell 0: advance every cycle
    for (int t = 0; t < 10; t++) begin
      applyStimulus(1, 1, 3'd0, 1, 16'd0);
      if (!BLANK_ON) checkOutput("step_hold", 32'(step8), 32'd1);
    end

    // Lower dwell from 10 to 1 with the count at 5
    applyStimulus(1, 0, 3'd0, 1, 16'd10);
    applyStimulus(1, 1, 3'd0, 1, 16'd10);
    for (int t = 0; t < 5; t++) applyStimulus(1, 1, 3'd0, 1, 16'd10);
    checkOutput("cnt5_nostep", 32'(step8), 32'd0);
    applyStimulus(1, 1, 3'd0, 1, 16'd1);
    checkOutput("lower_step", 32'(step8), 32'd1);
    checkOutput("lower_idx",  32'(idx8),  32'd1);

    // Async reset mid-scan at index 4
    applyStimulus(1, 0, 3'd0, 1, 16'd1);
    applyStimulus(1, 1, 3'd0, 1, 16'd1);
    guard = 0;
    while (!(m_idx[0] == 4 && m_state[0] == DWL_S) && guard < 60) begin
      applyStimulus(1, 1, 3'd0, 1, 16'd1);
      guard++;
    end
    checkOutput("pre_rst_idx", 32'(idx8), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_y8",   32'(y8),    32'hFF);
    checkOutput("arst_idx8", 32'(idx8),  32'd0);
    checkOutput("arst_y6",   32'({2'b00, y6}), 32'h3F);
    modelReset();
    #1 rst_n = 1'b1;
    applyStimulus(1, 1, 3'd0, 1, 16'd1);
    checkOutput("restart_y8",  32'(y8),   32'h01);
    checkOutput("restart_idx", 32'(idx8), 32'd0);
    applyStimulus(1, 1, 3'd0, 0, 16'd1);
    checkOutput("opt_inv", 32'(y8), 32'hFE);
    for (int t = 0; t < 6; t++) applyStimulus(1, 1, 3'd0, 1'(t % 2), 16'd1);

    // Enable drop mid-scan, then re-enable
    applyStimulus(0, 1, 3'd0, 1, 16'd1);
    checkOutput("off_y8",  32'(y8),   32'h00);
    checkOutput("off_idx", 32'(idx8), 32'd0);
    applyStimulus(1, 1, 3'd0, 1, 16'd1);
    checkOutput("reen_y8",   32'(y8),    32'h01);
    checkOutput("reen_step", 32'(step8), 32'd0);
    for (int t = 0; t < 5; t++) applyStimulus(1, 1, 3'd0, 1, 16'd1);

    // Scan back to direct
    applyStimulus(1, 0, 3'd3, 1, 16'd1);
    checkOutput("back_direct", 32'(y8), 32'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
